// File: rtl/sprite_evaluator.sv
// Per-scanline sprite evaluation: clears secondary OAM, scans primary OAM, copies in-range sprites.
// Optional macro OVERFLOW_BUG_EN reproduces the diagonal-byte overflow scan of the original PPU.
`timescale 1ns/1ps
module sprite_evaluator #(
  parameter int SPRITES_MAX = 8,
  parameter int OAM_ENTRIES = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clock_EN,
  input  logic       start,
  input  logic       rendering_en,
  input  logic [8:0] scanline,
  input  logic       sprite_size_16,
  input  logic       overflow_clear,
  output logic [7:0] oam_address,
  input  logic [7:0] oam_dataIn,
  output logic       sec_write,
  output logic [4:0] sec_address,
  output logic [7:0] sec_dataOut,
  output logic [3:0] sprite_count,
  output logic       sprite_zero_in_range,
  output logic       sprite_overflow,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_EVAL_Y, S_COPY, S_OVF_SCAN, S_DONE
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'(SPRITES_MAX);
  localparam logic [4:0] C_LAST  = 5'(4 * SPRITES_MAX - 1);
  localparam logic [5:0] N_LAST  = 6'(OAM_ENTRIES - 1);

  state_t     state_q, state_d;
  logic [5:0] n_q, n_d;
  logic [1:0] m_q, m_d;
  logic [4:0] c_q, c_d;
  logic [3:0] count_q, count_d;
  logic       zero_q, zero_d;
  logic       ovf_q, ovf_d;
  logic       ovf_set;
  logic       wr_req;

  // Whatever byte is on the OAM bus is tested as a Y coordinate.
  logic [9:0] diff;
  logic [9:0] height;
  logic       in_range;

  assign diff     = {1'b0, scanline} - {2'b00, oam_dataIn};
  assign height   = sprite_size_16 ? 10'd16 : 10'd8;
  assign in_range = ~diff[9] && (diff < height);

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    m_d         = m_q;
    c_d         = c_q;
    count_d     = count_q;
    zero_d      = zero_q;
    ovf_set     = 1'b0;
    wr_req      = 1'b0;
    oam_address = 8'd0;
    sec_address = 5'd0;
    sec_dataOut = 8'd0;

    case (state_q)
      S_CLEAR: begin
        wr_req      = 1'b1;
        sec_address = c_q;
        sec_dataOut = 8'hFF;
        c_d         = c_q + 5'd1;
        if (c_q == C_LAST) begin
          state_d = S_EVAL_Y;
          n_d     = 6'd0;
          m_d     = 2'd0;
        end
      end

      S_EVAL_Y: begin
        oam_address = {n_q, 2'b00};
        if (in_range && (count_q < CNT_MAX)) begin
          wr_req      = 1'b1;
          sec_address = {count_q[2:0], 2'b00};
          sec_dataOut = oam_dataIn;
          if (n_q == 6'd0) zero_d = 1'b1;
          m_d     = 2'd1;
          state_d = S_COPY;
        end else begin
          n_d = n_q + 6'd1;
          if (n_q == N_LAST) state_d = S_DONE;
        end
      end

      S_COPY: begin
        oam_address = {n_q, m_q};
        wr_req      = 1'b1;
        sec_address = {count_q[2:0], m_q};
        sec_dataOut = oam_dataIn;
        m_d         = m_q + 2'd1;
        if (m_q == 2'd3) begin
          count_d = count_q + 4'd1;
          n_d     = n_q + 6'd1;
          if (n_q == N_LAST)                    state_d = S_DONE;
          else if (count_q + 4'd1 == CNT_MAX)   state_d = S_OVF_SCAN;
          else                                  state_d = S_EVAL_Y;
        end
      end

      S_OVF_SCAN: begin
        oam_address = {n_q, m_q};
        if (in_range) begin
          ovf_set = 1'b1;
          state_d = S_DONE;
        end else begin
          n_d = n_q + 6'd1;
`ifdef OVERFLOW_BUG_EN
          m_d = m_q + 2'd1;
`else
          m_d = 2'd0;
`endif
          if (n_q == N_LAST) state_d = S_DONE;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_IDLE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A start restarts from any state; overflow deliberately survives it.
    if (start && rendering_en) begin
      state_d = S_CLEAR;
      c_d     = 5'd0;
      n_d     = 6'd0;
      m_d     = 2'd0;
      count_d = 4'd0;
      zero_d  = 1'b0;
    end

    // Rendering off aborts silently; results gathered so far are kept as-is.
    if (!rendering_en) begin
      state_d = S_IDLE;
      count_d = count_q;
      zero_d  = zero_q;
      ovf_set = 1'b0;
    end

    if (ovf_set)             ovf_d = 1'b1;
    else if (overflow_clear) ovf_d = 1'b0;
    else                     ovf_d = ovf_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      n_q     <= 6'd0;
      m_q     <= 2'd0;
      c_q     <= 5'd0;
      count_q <= 4'd0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clock_EN) begin
      state_q <= state_d;
      n_q     <= n_d;
      m_q     <= m_d;
      c_q     <= c_d;
      count_q <= count_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sec_write            = wr_req & rendering_en;
  assign sprite_count         = count_q;
  assign sprite_zero_in_range = zero_q;
  assign sprite_overflow      = ovf_q;
  assign done                 = (state_q == S_DONE);
  assign busy                 = (state_q == S_CLEAR) || (state_q == S_EVAL_Y) ||
                                (state_q == S_COPY)  || (state_q == S_OVF_SCAN);

endmodule

// File: tb/tb_sprite_evaluator.sv
// Randomized bench for sprite_evaluator against a behavioural scanline model.
`timescale 1ns/1ps
module tb_sprite_evaluator;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       clock_EN;
  logic       start = 1'b0;
  logic       rendering_en = 1'b1;
  logic [8:0] scanline = 9'd0;
  logic       sprite_size_16 = 1'b0;
  logic       overflow_clear = 1'b0;
  logic [7:0] oam_address;
  logic [7:0] oam_dataIn;
  logic       sec_write;
  logic [4:0] sec_address;
  logic [7:0] sec_dataOut;
  logic [3:0] sprite_count;
  logic       sprite_zero_in_range;
  logic       sprite_overflow;
  logic       busy;
  logic       done;

  sprite_evaluator dut (
    .clock(clock), .reset_n(reset_n), .clock_EN(clock_EN), .start(start),
    .rendering_en(rendering_en), .scanline(scanline), .sprite_size_16(sprite_size_16),
    .overflow_clear(overflow_clear), .oam_address(oam_address), .oam_dataIn(oam_dataIn),
    .sec_write(sec_write), .sec_address(sec_address), .sec_dataOut(sec_dataOut),
    .sprite_count(sprite_count), .sprite_zero_in_range(sprite_zero_in_range),
    .sprite_overflow(sprite_overflow), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Dot enable: high on one clock out of every en_div.
  int en_div = 1;
  int div_cnt = 0;
  always @(negedge clock) div_cnt <= (div_cnt + 1) % en_div;
  assign clock_EN = (div_cnt == 0);

  logic [7:0] oam [256];
  assign oam_dataIn = oam[oam_address];

  // Captured secondary OAM plus write/done event counters.
  logic [7:0] sec_mem [32];
  int wr_cnt = 0;
  int done_cnt = 0;
  always @(posedge clock) begin
    if (clock_EN && sec_write) begin
      sec_mem[sec_address] <= sec_dataOut;
      wr_cnt <= wr_cnt + 1;
    end
    if (clock_EN && done) done_cnt <= done_cnt + 1;
  end

  int n_total = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference results
  logic [7:0] exp_sec [32];
  int exp_cnt, exp_cycles;
  bit exp_zero, exp_ovf_new, exp_ovf_q;

  function automatic bit hit(input int sl, input logic [7:0] y, input bit tall);
    int d;
    d = sl - int'(y);
    return (d >= 0) && (d < (tall ? 16 : 8));
  endfunction

  task automatic ref_model(input int sl, input bit tall);
    int n, m;
    for (int i = 0; i < 32; i++) exp_sec[i] = 8'hFF;
    exp_cnt = 0; exp_zero = 0; exp_ovf_new = 0; exp_cycles = 32;
    n = 0;
    while (n < 64 && exp_cnt < 8) begin
      if (hit(sl, oam[4*n], tall)) begin
        for (int b = 0; b < 4; b++) exp_sec[4*exp_cnt + b] = oam[4*n + b];
        if (n == 0) exp_zero = 1;
        exp_cnt++;
        exp_cycles += 4;
      end else begin
        exp_cycles += 1;
      end
      n++;
    end
    if (exp_cnt == 8) begin
      m = 0;
      while (n < 64) begin
        exp_cycles++;
        if (hit(sl, oam[4*n + m], tall)) begin
          exp_ovf_new = 1;
          break;
        end
        n++;
`ifdef OVERFLOW_BUG_EN
        m = (m + 1) % 4;
`endif
      end
    end
  endtask

  task automatic wait_en(input int k);
    for (int i = 0; i < k; i++) begin
      do @(posedge clock); while (!clock_EN);
    end
    @(negedge clock);
  endtask

  task automatic kick();
    @(negedge clock); start = 1'b1;
    do @(posedge clock); while (!clock_EN);
    @(negedge clock); start = 1'b0;
  endtask

  task automatic clear_ovf();
    @(negedge clock); overflow_clear = 1'b1;
    do @(posedge clock); while (!clock_EN);
    @(negedge clock); overflow_clear = 1'b0;
    exp_ovf_q = 0;
    chk("ovf_clear", sprite_overflow, 0);
  endtask

  task automatic do_eval(input logic [8:0] sl, input bit tall, input int div, input string name);
    int edges, clocks;
    bit got;
    en_div = div;
    scanline = sl;
    sprite_size_16 = tall;
    ref_model(int'(sl), tall);
    kick();
    chk({name, ".first"}, {sec_write, sec_address, sec_dataOut, sprite_count, sprite_zero_in_range, busy},
        {1'b1, 5'd0, 8'hFF, 4'd0, 1'b0, 1'b1});
    edges = 0; clocks = 0; got = 0;
    while (!got && clocks < 5000) begin
      @(posedge clock);
      clocks++;
      if (clock_EN) edges++;
      @(negedge clock);
      if (done) got = 1;
    end
    chk({name, ".done"}, got, 1);
    chk({name, ".edges"}, edges, exp_cycles);
    chk({name, ".clocks"}, clocks, exp_cycles * div);
    exp_ovf_q = exp_ovf_q | exp_ovf_new;
    chk({name, ".count"}, sprite_count, exp_cnt);
    chk({name, ".zero"}, sprite_zero_in_range, exp_zero);
    chk({name, ".ovf"}, sprite_overflow, exp_ovf_q);
    for (int s = 0; s < 8; s++)
      chk({name, ".sec"}, {sec_mem[4*s], sec_mem[4*s+1], sec_mem[4*s+2], sec_mem[4*s+3]},
          {exp_sec[4*s], exp_sec[4*s+1], exp_sec[4*s+2], exp_sec[4*s+3]});
    wait_en(1);
    chk({name, ".after"}, {done, busy}, 0);
    $display("eval %s: scanline=%0d tall=%0d div=%0d count=%0d zero=%0d ovf=%0d cycles=%0d",
             name, sl, tall, div, sprite_count, sprite_zero_in_range, sprite_overflow, edges);
  endtask

  task automatic oam_far();
    for (int i = 0; i < 256; i++) oam[i] = ((i % 4) == 0) ? 8'hF8 : 8'($urandom);
  endtask

  task automatic oam_default();
    oam_far();
    oam[0] = 8'h18; oam[1] = 8'hFF; oam[2] = 8'h23; oam[3] = 8'h58;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, d, sl;
    bit bug_exp;
    exp_ovf_q = 0;
    oam_default();
    repeat (3) @(negedge clock);
    chk("reset.outs", {oam_address, sec_write, sec_address, sec_dataOut, sprite_count,
                       sprite_zero_in_range, sprite_overflow, busy, done}, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Single sprite zero hit, rest far away
    oam_default();
    do_eval(9'h01A, 0, 1, "default");
    chk("default.sec0", {sec_mem[0], sec_mem[1], sec_mem[2], sec_mem[3]}, 32'h18FF2358);
    chk("default.cnt1", sprite_count, 1);

    // Ten stacked sprites
    oam_far();
    for (int i = 0; i < 10; i++) oam[4*i] = 8'h40;
    do_eval(9'h047, 0, 1, "ten_8x8");
    chk("ten.ovf1", sprite_overflow, 1);
    clear_ovf();
    do_eval(9'h048, 0, 1, "ten_below");
    chk("ten_below.cnt0", sprite_count, 0);
    do_eval(9'h04F, 1, 1, "ten_8x16");
    chk("ten16.cnt8", sprite_count, 8);

    // Diagonal-byte overflow case
    clear_ovf();
    for (int i = 0; i < 256; i++) oam[i] = (i < 32) ? 8'($urandom) : 8'hF8;
    for (int i = 0; i < 8; i++) oam[4*i] = 8'h40;
    oam[37] = 8'h40;
`ifdef OVERFLOW_BUG_EN
    bug_exp = 1;
`else
    bug_exp = 0;
`endif
    do_eval(9'h040, 0, 1, "diag");
    chk("diag.ovf", sprite_overflow, bug_exp);

    // Rendering dropped mid-scan
    oam_default();
    scanline = 9'h01A; sprite_size_16 = 1'b0; en_div = 1;
    kick();
    wait_en(40);
    rendering_en = 1'b0;
    w = wr_cnt; d = done_cnt;
    wait_en(1);
    chk("drop.busy", busy, 0);
    repeat (5) @(negedge clock);
    rendering_en = 1'b1;
    repeat (200) @(negedge clock);
    chk("drop.writes", wr_cnt - w, 0);
    chk("drop.done", done_cnt - d, 0);
    chk("drop.hold", {sprite_count, sprite_zero_in_range, busy}, {4'd1, 1'b1, 1'b0});
    $display("drop: count=%0d zero=%0d busy=%0d", sprite_count, sprite_zero_in_range, busy);

    // Restart while busy
    oam_far();
    for (int i = 0; i < 12; i += 3) oam[4*i] = 8'h30;
    scanline = 9'h032; en_div = 1;
    kick();
    wait_en(50);
    do_eval(9'h032, 0, 1, "restart");

    // Slow dot enable gives the same results, four times slower
    oam_default();
    do_eval(9'h01A, 0, 4, "div4");

    // Reset while copying
    oam_default();
    scanline = 9'h01A; sprite_size_16 = 1'b0; en_div = 1;
    kick();
    wait_en(34);
    chk("rstcopy.mid", {busy, sec_write, sec_address}, {1'b1, 1'b1, 5'd2});
    #2 reset_n = 1'b0;
    #1 chk("rstcopy.outs", {oam_address, sec_write, sec_address, sec_dataOut, sprite_count,
                            sprite_zero_in_range, sprite_overflow, busy, done}, 0);
    exp_ovf_q = 0;
    @(negedge clock); reset_n = 1'b1;
    w = wr_cnt;
    repeat (20) @(negedge clock);
    chk("rstcopy.nowr", wr_cnt - w, 0);
    chk("rstcopy.idle", {busy, done, sprite_count}, 0);
    $display("reset mid-copy: busy=%0d count=%0d", busy, sprite_count);

    // Randomized scanlines
    for (int t = 0; t < 10; t++) begin
      sl = $urandom_range(0, 261);
      for (int i = 0; i < 64; i++) begin
        oam[4*i] = ($urandom_range(0, 2) == 0) ? 8'(sl - $urandom_range(0, 17)) : 8'($urandom);
        for (int b = 1; b < 4; b++)
          oam[4*i + b] = ($urandom_range(0, 3) == 0) ? 8'(sl - $urandom_range(0, 9)) : 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) clear_ovf();
      do_eval(9'(sl), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 4 : 1, $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
